// File: rtl/mesi_pkg.sv
// Shared types for the MESI set-associative controller.
// Line states, bus ops, snoop results, trace codes and width helper.
package mesi_pkg;

  typedef enum logic [1:0] {
    ST_E = 2'b00,
    ST_M = 2'b01,
    ST_S = 2'b10,
    ST_I = 2'b11
  } states_t;

  typedef enum logic [2:0] {
    BUS_NONE  = 3'd0,
    BUS_READ  = 3'd1,
    BUS_WRITE = 3'd2,
    BUS_INVAL = 3'd3,
    BUS_RWIM  = 3'd4
  } busop_t;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snoop_t;

  typedef enum logic {
    FSM_IDLE,
    FSM_CLEAR
  } fsm_t;

  localparam logic [3:0] CMD_RD      = 4'd0;
  localparam logic [3:0] CMD_WR      = 4'd1;
  localparam logic [3:0] CMD_IFETCH  = 4'd2;
  localparam logic [3:0] CMD_SNP_INV = 4'd3;
  localparam logic [3:0] CMD_SNP_RD  = 4'd4;
  localparam logic [3:0] CMD_SNP_WR  = 4'd5;
  localparam logic [3:0] CMD_SNP_RFO = 4'd6;
  localparam logic [3:0] CMD_CLEAR   = 4'd8;
  localparam logic [3:0] CMD_PRINT   = 4'd9;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mesi_set_assoc_ctrl_plru.sv
// Tree pseudo-LRU: victim walk and touch update for one set.
// Bit 0 at a node points the victim to the left subtree.
module plru_tree
  import mesi_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  localparam int WAY_W = clog2_min1(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] bits,
  input  logic [WAY_W-1:0]    touch,
  output logic [WAY_W-1:0]    victim,
  output logic [NUM_WAYS-2:0] next_bits
);

  localparam int NODE_W = WAY_W + 1;

  logic [2*NUM_WAYS-1:0] tree;
  logic [NODE_W-1:0]     vnode;
  logic [NODE_W-1:0]     unode;

  always_comb begin
    tree  = {{(NUM_WAYS+1){1'b0}}, bits};
    vnode = '0;
    for (int l = 0; l < WAY_W; l++)
      vnode = (vnode << 1) + NODE_W'(1)
            + NODE_W'(tree[vnode]);
    victim = WAY_W'(vnode - NODE_W'(NUM_WAYS - 1));
  end

  // Each node on the path turns away from the touched way.
  always_comb begin
    next_bits = bits;
    unode     = '0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int i = 0; i < NUM_WAYS - 1; i++)
        if (unode == NODE_W'(i))
          next_bits[i] = ~touch[WAY_W-1-l];
      unode = (unode << 1) + NODE_W'(1)
            + NODE_W'(touch[WAY_W-1-l]);
    end
  end

endmodule

// File: rtl/mesi_set_assoc_ctrl.sv
// MESI state/tag array with tree PLRU, clear sweep
// and a registered single-cycle response stage.
module mesi_set_assoc_ctrl
  import mesi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 4,
  parameter int LINE_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_n,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        snoop_in,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [1:0]        resp_state,
  output logic [2:0]        busop,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [1:0]        snoop_out,
  output logic              resp_err
);

  localparam int OFF_W = clog2_min1(LINE_BYTES);
  localparam int IDX_W = clog2_min1(NUM_SETS);
  localparam int WAY_W = clog2_min1(NUM_WAYS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  logic [TAG_W-1:0]    tags [NUM_SETS][NUM_WAYS];
  states_t             st   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-2:0] plru [NUM_SETS];
  fsm_t                fsm;
  logic [IDX_W-1:0]    clr_set;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [ADDR_W-1:0]   line_addr;
  logic [ADDR_W-1:0]   vic_addr;
  logic [NUM_WAYS-1:0] match;
  logic                hit;
  logic                has_inv;
  logic                accept;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    lru_way;
  logic [WAY_W-1:0]    vic_way;
  logic [WAY_W-1:0]    way_sel;
  logic [NUM_WAYS-2:0] plru_nxt;
  states_t             cur;
  states_t             vic_st;
  states_t             n_state;
  busop_t              n_bus;
  snoop_t              n_snp;
  snoop_t              snp;
  logic                n_hit;
  logic                n_wb;
  logic                n_err;
  logic                wr_state;
  logic                wr_tag;
  logic                touch;
  logic                unused_off;

  assign idx        = req_addr[OFF_W +: IDX_W];
  assign tag        = req_addr[ADDR_W-1 -: TAG_W];
  assign unused_off = ^req_addr[OFF_W-1:0];
  assign snp        = snoop_t'(snoop_in);
  assign accept     = (fsm == FSM_IDLE) && req_valid && req_ready;
  assign line_addr  = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

  // Invalid lines never match, so stale tags are harmless.
  always_comb begin
    match   = '0;
    hit_way = '0;
    inv_way = '0;
    has_inv = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (st[idx][w] != ST_I && tags[idx][w] == tag) begin
        match[w] = 1'b1;
        hit_way  = WAY_W'(w);
      end
      if (st[idx][w] == ST_I) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    hit = |match;
  end

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .bits      (plru[idx]),
    .touch     (way_sel),
    .victim    (lru_way),
    .next_bits (plru_nxt)
  );

  assign vic_way  = has_inv ? inv_way : lru_way;
  assign cur      = st[idx][hit_way];
  assign vic_st   = st[idx][vic_way];
  assign vic_addr = {tags[idx][vic_way], idx, OFF_W'(0)};

  always_comb begin
    n_state  = ST_I;
    n_hit    = 1'b0;
    n_bus    = BUS_NONE;
    n_snp    = SNP_NOHIT;
    n_wb     = 1'b0;
    n_err    = 1'b0;
    way_sel  = hit_way;
    wr_state = 1'b0;
    wr_tag   = 1'b0;
    touch    = 1'b0;
    unique case (1'b1)
      (req_n == CMD_RD || req_n == CMD_IFETCH): begin
        n_hit    = hit;
        wr_state = 1'b1;
        touch    = 1'b1;
        n_state  = cur;
        if (!hit) begin
          way_sel = vic_way;
          wr_tag  = 1'b1;
          n_wb    = (vic_st == ST_M);
          n_bus   = BUS_READ;
          n_state = (snp == SNP_HIT || snp == SNP_HITM)
                  ? ST_S : ST_E;
        end
      end
      (req_n == CMD_WR): begin
        n_hit    = hit;
        wr_state = 1'b1;
        touch    = 1'b1;
        n_state  = ST_M;
        if (hit) begin
          n_bus = (cur == ST_S) ? BUS_INVAL : BUS_NONE;
        end else begin
          way_sel = vic_way;
          wr_tag  = 1'b1;
          n_wb    = (vic_st == ST_M);
          n_bus   = BUS_RWIM;
        end
      end
      (req_n inside {CMD_SNP_INV, CMD_SNP_RD,
                     CMD_SNP_WR, CMD_SNP_RFO}): begin
        n_hit = hit;
        if (hit) begin
          wr_state = 1'b1;
          n_state  = cur;
          n_snp    = (cur == ST_M) ? SNP_HITM : SNP_HIT;
          if (req_n == CMD_SNP_RD)
            n_state = ST_S;
          else if (req_n != CMD_SNP_WR)
            n_state = ST_I;
          if (cur == ST_M && req_n != CMD_SNP_WR)
            n_bus = BUS_WRITE;
        end
      end
      (req_n == CMD_PRINT): begin
        n_hit   = hit;
        n_state = hit ? cur : ST_I;
      end
      (req_n == CMD_CLEAR): begin
        n_err = 1'b0;
      end
      default: begin
        n_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm        <= FSM_IDLE;
      clr_set    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_state <= 2'b00;
      busop      <= 3'd0;
      bus_addr   <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      snoop_out  <= 2'd0;
      resp_err   <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        plru[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          tags[s][w] <= '0;
          st[s][w]   <= ST_I;
        end
      end
    end else begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_state <= 2'b00;
      busop      <= 3'd0;
      bus_addr   <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      snoop_out  <= 2'd0;
      resp_err   <= 1'b0;
      unique case (fsm)
        FSM_IDLE: begin
          req_ready <= 1'b1;
          if (accept && req_n == CMD_CLEAR) begin
            fsm       <= FSM_CLEAR;
            req_ready <= 1'b0;
            clr_set   <= '0;
          end else if (accept) begin
            resp_valid <= 1'b1;
            resp_hit   <= n_hit;
            resp_state <= n_state;
            busop      <= n_bus;
            bus_addr   <= (n_bus != BUS_NONE) ? line_addr : '0;
            wb_valid   <= n_wb;
            wb_addr    <= n_wb ? vic_addr : '0;
            snoop_out  <= n_snp;
            resp_err   <= n_err;
            if (wr_state) st[idx][way_sel] <= n_state;
            if (wr_tag) tags[idx][way_sel] <= tag;
            if (touch) plru[idx] <= plru_nxt;
          end
        end
        FSM_CLEAR: begin
          for (int w = 0; w < NUM_WAYS; w++)
            st[clr_set][w] <= ST_I;
          plru[clr_set] <= '0;
          clr_set       <= clr_set + 1'b1;
          if (clr_set == IDX_W'(NUM_SETS - 1)) begin
            fsm        <= FSM_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b1;
            resp_state <= ST_I;
          end
        end
        default: fsm <= FSM_IDLE;
      endcase
    end
  end

  a_one_way: assert property (@(posedge clk) disable iff (!rst)
    accept |-> $onehot0(match));

endmodule
